// File: rtl/i2c_master_read_byte_pkg.sv
// rtl/i2c_master_read_byte_pkg.sv - shared command codes and FSM types for the I2C byte engines
package i2c_master_read_byte_pkg;

  // Command codes shared by the read-byte and write-byte engines.
  typedef enum logic [2:0] {
    CMD_START     = 3'b001,
    CMD_READ_DATA = 3'b010,
    CMD_WRITE     = 3'b011,
    CMD_STOP      = 3'b100,
    CMD_NACK      = 3'b101,
    CMD_READ_ACK  = 3'b110,
    CMD_ACK       = 3'b111
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_read_cmd(input logic [2:0] cmd);
    return (cmd == CMD_READ_DATA) || (cmd == CMD_READ_ACK);
  endfunction

endpackage

// File: rtl/i2c_master_read_byte_if.sv
// rtl/i2c_master_read_byte_if.sv - sequencer-facing handshake and bus signals of the read engine
interface i2c_master_read_byte_if;

  logic       go;
  logic [2:0] command;
  logic       sda_in;
  logic       scl;
  logic       data;
  logic       store;
  logic [7:0] byte_out;
  logic       ack;
  logic       finish;
  logic       error;

  modport master (
    input  go, command, sda_in,
    output scl, data, store, byte_out, ack, finish, error
  );

  modport slave (
    output go, command, sda_in,
    input  scl, data, store, byte_out, ack, finish, error
  );

endinterface

// File: rtl/i2c_scl_timer.sv
// rtl/i2c_scl_timer.sv - SCL bit-cell timer: phase within a quarter and quarter within a bit
module i2c_scl_timer #(
  parameter int QUARTER = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       run_i,
  output logic [1:0] quarter_o,
  output logic       end_of_quarter_o,
  output logic       end_of_bit_o
);

  localparam int PW = $clog2(QUARTER);
  localparam logic [PW-1:0] LAST_PHASE = PW'(QUARTER - 1);

  logic [PW-1:0] phase_q, phase_d;
  logic [1:0]    quarter_q, quarter_d;

  assign end_of_quarter_o = run_i && (phase_q == LAST_PHASE);
  assign end_of_bit_o     = end_of_quarter_o && (quarter_q == 2'd3);
  assign quarter_o        = quarter_q;

  // Holding run_i low parks both counters at zero so every operation starts on a bit boundary.
  always_comb begin
    phase_d   = phase_q;
    quarter_d = quarter_q;
    if (!run_i) begin
      phase_d   = '0;
      quarter_d = 2'd0;
    end else if (end_of_quarter_o) begin
      phase_d   = '0;
      quarter_d = quarter_q + 2'd1;
    end else begin
      phase_d   = phase_q + PW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      phase_q   <= '0;
      quarter_q <= 2'd0;
    end else begin
      phase_q   <= phase_d;
      quarter_q <= quarter_d;
    end
  end

endmodule

// File: rtl/i2c_master_read_byte.sv
// rtl/i2c_master_read_byte.sv - I2C master receive engine: clocks in one data byte or one ACK bit
import i2c_master_read_byte_pkg::*;

module i2c_master_read_byte #(
  parameter int QUARTER = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  i2c_master_read_byte_if.master  bus
);

  state_e     state_q, state_d;
  cmd_e       cmd_q, cmd_d;
  logic       illegal_q, illegal_d;
  logic [2:0] bit_q, bit_d;
  logic [1:0] sync_q;
  logic       scl_q, scl_d;
  logic       data_q, data_d;
  logic       store_q, store_d;
  logic [7:0] byte_q, byte_d;
  logic       ack_q, ack_d;
  logic       finish_q, finish_d;
  logic       error_q, error_d;

  logic [1:0] quarter;
  logic       end_of_quarter;
  logic       end_of_bit;
  logic       sda_s;

  i2c_scl_timer #(.QUARTER(QUARTER)) u_timer (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .run_i            (state_q == ST_RUN),
    .quarter_o        (quarter),
    .end_of_quarter_o (end_of_quarter),
    .end_of_bit_o     (end_of_bit)
  );

  assign sda_s = sync_q[1];

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    illegal_d = illegal_q;
    bit_d     = bit_q;
    scl_d     = scl_q;
    data_d    = data_q;
    store_d   = 1'b0;
    byte_d    = byte_q;
    ack_d     = ack_q;
    finish_d  = finish_q;
    error_d   = error_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.go) begin
          if (is_read_cmd(bus.command)) begin
            state_d   = ST_RUN;
            cmd_d     = cmd_e'(bus.command);
            illegal_d = 1'b0;
            bit_d     = 3'd0;
          end else begin
            state_d   = ST_DONE;
            illegal_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        scl_d = quarter[1];
        // Sample late in the high-going quarter so the synchronizer delay is covered.
        if (end_of_quarter && (quarter == 2'd2)) begin
          data_d  = sda_s;
          store_d = 1'b1;
          if (cmd_q == CMD_READ_ACK) begin
            ack_d = ~sda_s;
          end else begin
            byte_d = {byte_q[6:0], sda_s};
          end
        end
        if (end_of_bit) begin
          bit_d = bit_q + 3'd1;
          if ((cmd_q == CMD_READ_ACK) || (bit_q == 3'd7)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // An illegal command never touched the bus, so scl keeps whatever level it had.
        if (!illegal_q) begin
          scl_d = 1'b0;
        end
        finish_d = 1'b1;
        error_d  = illegal_q;
        if (finish_q && !bus.go) begin
          state_d  = ST_IDLE;
          finish_d = 1'b0;
          error_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cmd_q     <= CMD_READ_DATA;
      illegal_q <= 1'b0;
      bit_q     <= 3'd0;
      sync_q    <= 2'b11;
      scl_q     <= 1'b1;
      data_q    <= 1'b0;
      store_q   <= 1'b0;
      byte_q    <= 8'h00;
      ack_q     <= 1'b0;
      finish_q  <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      illegal_q <= illegal_d;
      bit_q     <= bit_d;
      sync_q    <= {sync_q[0], bus.sda_in};
      scl_q     <= scl_d;
      data_q    <= data_d;
      store_q   <= store_d;
      byte_q    <= byte_d;
      ack_q     <= ack_d;
      finish_q  <= finish_d;
      error_q   <= error_d;
    end
  end

  assign bus.scl      = scl_q;
  assign bus.data     = data_q;
  assign bus.store    = store_q;
  assign bus.byte_out = byte_q;
  assign bus.ack      = ack_q;
  assign bus.finish   = finish_q;
  assign bus.error    = error_q;

endmodule

// File: tb/tb_i2c_master_read_byte.sv
// tb/tb_i2c_master_read_byte.sv - self-checking bench for the I2C master read-byte engine
module tb_i2c_master_read_byte;

  localparam int Q   = 4;
  localparam int BIT = 4 * Q;

  logic       clk = 1'b0;
  logic       rst;
  logic       go_r;
  logic [2:0] cmd_r;
  logic       sda_drv = 1'b1;
  logic [7:0] pat_next;

  always #5 clk = ~clk;

  i2c_master_read_byte_if bus();
  assign bus.go      = go_r;
  assign bus.command = cmd_r;
  assign bus.sda_in  = sda_drv;

  i2c_master_read_byte #(.QUARTER(Q)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Timeline model: everything follows from the edge at which go was accepted.
  int         e = 0;
  int         m_k, m_nbits, mn, mL, mb;
  bit         m_busy = 1'b0, m_illegal = 1'b0, m_ackop = 1'b0;
  logic [7:0] m_pat = 8'h00;
  logic       m_scl = 1'b1, m_data = 1'b0, m_store = 1'b0, m_ack = 1'b0, m_fin = 1'b0, m_err = 1'b0;
  logic [7:0] m_byte = 8'h00;
  logic       bitv;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0; m_scl = 1'b1; m_data = 1'b0; m_store = 1'b0;
      m_ack = 1'b0; m_fin = 1'b0; m_err = 1'b0; m_byte = 8'h00;
    end else begin
      e = e + 1;
      m_store = 1'b0;
      if (!m_busy) begin
        if (go_r) begin
          m_busy = 1'b1;
          m_k    = e;
          if (cmd_r == 3'b010 || cmd_r == 3'b110) begin
            m_illegal = 1'b0;
            m_ackop   = (cmd_r == 3'b110);
            m_nbits   = m_ackop ? 1 : 8;
            m_pat     = pat_next;
          end else begin
            m_illegal = 1'b1;
          end
        end
      end else begin
        mn = e - m_k;
        if (m_illegal) begin
          if (mn == 1) begin
            m_fin = 1'b1; m_err = 1'b1;
          end else if (!go_r) begin
            m_busy = 1'b0; m_fin = 1'b0; m_err = 1'b0;
          end
        end else begin
          mL = m_nbits * BIT;
          if (mn <= mL) m_scl = (((mn - 1) % BIT) >= 2 * Q);
          else if (mn == mL + 1) begin
            m_scl = 1'b0; m_fin = 1'b1;
          end
          if (mn >= 3 * Q && ((mn - 3 * Q) % BIT) == 0 && ((mn - 3 * Q) / BIT) < m_nbits) begin
            mb = (mn - 3 * Q) / BIT;
            bitv = m_pat[7 - mb];
            m_store = 1'b1;
            m_data  = bitv;
            if (m_ackop) m_ack = ~bitv;
            else m_byte = {m_byte[6:0], bitv};
          end
          if (mn >= mL + 2 && !go_r) begin
            m_busy = 1'b0; m_fin = 1'b0;
          end
        end
      end
    end
  end

  // Slave: present bit b for the whole of bit cell b, changing while SCL is low.
  int sn, sb;
  always @(negedge clk) begin
    if (m_busy && !m_illegal) begin
      sn = e - m_k;
      if (sn <= m_nbits * BIT) begin
        sb = (sn < 1) ? 0 : (sn - 1) / BIT;
        sda_drv = m_pat[7 - sb];
      end else begin
        sda_drv = 1'b1;
      end
    end else begin
      sda_drv = 1'b1;
    end
  end

  int checks = 0, failures = 0;
  int st_cnt = 0, scl_rises = 0;
  logic [7:0] st_bits = 8'h00;
  logic       prev_scl = 1'b1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic run_op(input logic [2:0] cmd, input logic [7:0] pat, input int hold,
                        input int exp_lat, input bit glitch);
    int lat;
    @(negedge clk);
    pat_next = pat; cmd_r = cmd; go_r = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #2;
      lat++;
      if (glitch && lat == 5) cmd_r = 3'b001;
    end while (!bus.finish && lat < 400);
    check("finish_latency", lat - 1, exp_lat);
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #2;
      check("finish_held_in_done", bus.finish, 1);
    end
    @(negedge clk);
    go_r = 1'b0;
    @(posedge clk); #2;
    check("finish_clear_after_go_low", bus.finish, 0);
  endtask

  initial begin
    int st0, r0, w;
    rst = 1'b1; go_r = 1'b0; cmd_r = 3'b010; pat_next = 8'h00;
    fork
      forever begin
        @(posedge clk); #2;
        if (!rst) begin
          checks++;
          if ({bus.scl, bus.data, bus.store, bus.ack, bus.finish, bus.error, bus.byte_out} !==
              {m_scl, m_data, m_store, m_ack, m_fin, m_err, m_byte}) begin
            failures++;
            $display("FAIL cycle_model e=%0d got scl%b d%b st%b ack%b fin%b err%b byte=%h expected scl%b d%b st%b ack%b fin%b err%b byte=%h",
                     e, bus.scl, bus.data, bus.store, bus.ack, bus.finish, bus.error, bus.byte_out,
                     m_scl, m_data, m_store, m_ack, m_fin, m_err, m_byte);
          end
          if (bus.store) begin
            st_cnt++;
            st_bits = {st_bits[6:0], bus.data};
          end
          if (bus.scl && !prev_scl) scl_rises++;
          prev_scl = bus.scl;
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {bus.scl, bus.data, bus.store, bus.ack, bus.finish, bus.error, bus.byte_out},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
    @(negedge clk);
    rst = 1'b0;

    // Illegal command: immediate finish+error, bus untouched.
    r0 = scl_rises;
    @(negedge clk);
    cmd_r = 3'b001; go_r = 1'b1;
    @(posedge clk); #2;
    @(posedge clk); #2;
    check("illegal_finish_error_scl", {bus.finish, bus.error, bus.scl}, 3'b111);
    @(negedge clk);
    go_r = 1'b0;
    @(posedge clk); #2;
    check("illegal_clear", {bus.finish, bus.error}, 2'b00);
    check("illegal_no_scl_pulse", scl_rises - r0, 0);

    // Data byte 0xA5.
    st0 = st_cnt;
    run_op(3'b010, 8'hA5, 0, 129, 1'b0);
    check("a5_store_count", st_cnt - st0, 8);
    check("a5_stored_bits", st_bits, 8'hA5);
    check("a5_byte_out", bus.byte_out, 8'hA5);

    // ACK bits: low -> ack, high -> nack, byte untouched.
    st0 = st_cnt;
    run_op(3'b110, 8'h00, 0, 17, 1'b0);
    check("ack_low_result", {bus.ack, bus.byte_out}, {1'b1, 8'hA5});
    check("ack_store_count", st_cnt - st0, 1);
    run_op(3'b110, 8'h80, 0, 17, 1'b0);
    check("nack_high_result", {bus.ack, bus.byte_out}, {1'b0, 8'hA5});

    // Reset after the third store of a byte.
    st0 = st_cnt;
    @(negedge clk);
    pat_next = 8'h5A; cmd_r = 3'b010; go_r = 1'b1;
    w = 0;
    do begin
      @(posedge clk); #3;
      w++;
    end while ((st_cnt - st0) < 3 && w < 200);
    check("third_store_seen", st_cnt - st0, 3);
    rst = 1'b1;
    #1;
    check("mid_op_reset_outputs", {bus.scl, bus.data, bus.store, bus.ack, bus.finish, bus.error, bus.byte_out},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
    @(negedge clk);
    go_r = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_op(3'b010, 8'h3C, 0, 129, 1'b0);
    check("after_reset_byte", bus.byte_out, 8'h3C);

    // go held in DONE, command glitch mid-run, then back-to-back DATA and ACK.
    r0 = scl_rises;
    run_op(3'b010, 8'hC3, 20, 129, 1'b1);
    check("held_byte", bus.byte_out, 8'hC3);
    run_op(3'b110, 8'h00, 0, 17, 1'b0);
    check("b2b_scl_pulses", scl_rises - r0, 9);
    check("b2b_ack", bus.ack, 1);

    repeat (4) @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
